// File: rtl/serial_comparator_pkg.sv
// Shared encodings for the digit-serial magnitude comparator.
// Result constants are ordered {gt, eq, lt} to match the output bundle.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/serial_comparator_digit_cmp.sv
// Purely combinational unsigned compare of one DIGIT-bit digit pair.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial comparator: examines operands MSB digit first and stops at the
// first differing digit. Signed mode flips both MSBs so unsigned digits suffice.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGIT  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             done,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(SIGNED != 0) << (WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic [2:0]       res_pend;
  logic             d_gt, d_eq, d_lt;
  logic             accept, last, finish;

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x  (a_sh[WIDTH-1 -: DIGIT]),
    .y  (b_sh[WIDTH-1 -: DIGIT]),
    .gt (d_gt),
    .eq (d_eq),
    .lt (d_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    accept      = start_valid && (state == IDLE);
    last        = (cnt == LAST);
    finish      = !d_eq || last;
    case (state)
      IDLE:    if (start_valid) state_n = CMP;
      CMP:     if (finish)      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Results only move in DONE, so gt/eq/lt hold between done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      res_pend <= '0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh <= a ^ MSB_MASK;
        b_sh <= b ^ MSB_MASK;
        cnt  <= '0;
      end else if (state == CMP) begin
        if (finish) begin
          res_pend <= d_gt ? GT : (d_lt ? LT : EQ);
        end else begin
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
          cnt  <= cnt + CW'(1);
        end
      end else if (state == DONE) begin
        {gt, eq, lt} <= res_pend;
        done         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: six instances cover DIGIT 4/1/16 in
// unsigned and signed mode, each driven by its own start_valid.
module tb_serial_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  sv = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [5:0]  sr, gt_v, eq_v, lt_v, done_v, busy_v;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Instance k: DIGIT 4 for k<2, 1 for k<4, else 16; odd k is signed.
  for (genvar i = 0; i < 6; i++) begin : g_dut
    serial_comparator #(
      .WIDTH  (16),
      .DIGIT  ((i < 2) ? 4 : ((i < 4) ? 1 : 16)),
      .SIGNED (i % 2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (sv[i]),
      .start_ready (sr[i]),
      .a           (a),
      .b           (b),
      .gt          (gt_v[i]),
      .eq          (eq_v[i]),
      .lt          (lt_v[i]),
      .done        (done_v[i]),
      .busy        (busy_v[i])
    );
  end

  function automatic int dg_of(input int k);
    return (k < 2) ? 4 : ((k < 4) ? 1 : 16);
  endfunction

  function automatic bit sg_of(input int k);
    return (k % 2) == 1;
  endfunction

  function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y, input bit sg);
    if (sg) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int ref_len(input logic [15:0] x, input logic [15:0] y, input int dg);
    int n;
    int mask;
    n = 16 / dg;
    mask = (1 << dg) - 1;
    for (int i = 0; i < n; i++) begin
      if ((((x >> (16 - dg * (i + 1))) & mask)) != (((y >> (16 - dg * (i + 1))) & mask)))
        return i + 1;
    end
    return n;
  endfunction

  // Accept on the next edge; lat = edges from accept to the done cycle, -1 on timeout.
  task automatic run_cmp(input int k, input logic [15:0] aa, input logic [15:0] bb,
                         output int lat, output logic [2:0] res);
    @(negedge clk);
    a = aa;
    b = bb;
    sv[k] = 1'b1;
    @(posedge clk);
    #1;
    sv[k] = 1'b0;
    lat = -1;
    res = 3'bxxx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done_v[k]) begin
        lat = c;
        res = {gt_v[k], eq_v[k], lt_v[k]};
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sv = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_v !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b expected %b", done_v, 6'b0);
    end
    checks++;
    if ({gt_v, eq_v, lt_v} !== 18'b0) begin
      errors++;
      $display("[TB] FAIL reset_result: got %b expected %b", {gt_v, eq_v, lt_v}, 18'b0);
    end
    checks++;
    if (busy_v !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected %b", busy_v, 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sr !== 6'h3f) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected %b", sr, 6'h3f);
    end
  endtask

  task automatic test_directed();
    int         lat;
    logic [2:0] res;
    logic [15:0] ta[5] = '{16'h1234, 16'h8000, 16'h8000, 16'h00F1, 16'h0F00};
    logic [15:0] tb[5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h00F2, 16'h0E00};
    int          tk[5] = '{0, 0, 1, 0, 0};
    int          tl[5] = '{5, 2, 2, 5, 3};
    logic [2:0]  tr[5] = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b100};
    for (int i = 0; i < 5; i++) begin
      run_cmp(tk[i], ta[i], tb[i], lat, res);
      checks++;
      if (lat !== tl[i]) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, tl[i]);
      end
      checks++;
      if (res !== tr[i]) begin
        errors++;
        $display("[TB] FAIL directed_result[%0d]: got %b expected %b", i, res, tr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_rd;
    logic [2:0] exp_res;
    @(negedge clk);
    a = 16'h0F00;
    b = 16'h0E00;
    sv[0] = 1'b1;
    @(posedge clk);
    #1;
    // Operands change while busy; they must only be taken at the second accept.
    a = 16'h1111;
    b = 16'h1111;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      exp_rd = (c == 3) || (c == 9);
      checks++;
      if ({sr[0], done_v[0]} !== {exp_rd, exp_rd}) begin
        errors++;
        $display("[TB] FAIL b2b_ready_done[c=%0d]: got %b expected %b", c, {sr[0], done_v[0]}, {exp_rd, exp_rd});
      end
      if (c >= 3) begin
        exp_res = (c == 9) ? 3'b010 : 3'b100;
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== exp_res) begin
          errors++;
          $display("[TB] FAIL b2b_result[c=%0d]: got %b expected %b", c, {gt_v[0], eq_v[0], lt_v[0]}, exp_res);
        end
      end
      if (c == 4) sv[0] = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    int         lat;
    logic [2:0] res;
    bit         saw_done;
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    sv[0] = 1'b1;
    @(posedge clk);
    #1;
    sv[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done_v[0], gt_v[0], eq_v[0], lt_v[0], busy_v[0]} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got %b expected %b", {done_v[0], gt_v[0], eq_v[0], lt_v[0], busy_v[0]}, 5'b0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sr[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_ready: got %b expected %b", sr[0], 1'b1);
    end
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_v[0]) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %b expected %b", saw_done, 1'b0);
    end
    run_cmp(0, 16'h1234, 16'h1233, lat, res);
    checks++;
    if (lat !== 5 || res !== 3'b100) begin
      errors++;
      $display("[TB] FAIL abort_recover: got lat=%0d res=%b expected lat=5 res=100", lat, res);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] va[12] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hABCD,
                            16'hFFFE, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] vb[12] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h1243, 16'hABCD,
                            16'hFFFF, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0};
    int          lat;
    int          exp_l;
    logic [2:0]  res;
    logic [2:0]  exp_r;
    for (int i = 8; i < 12; i++) begin
      va[i] = 16'($urandom_range(0, 65535));
      vb[i] = (i < 10) ? 16'($urandom_range(0, 65535)) : (va[i] ^ 16'(1 << $urandom_range(0, 15)));
    end
    for (int k = 0; k < 6; k++) begin
      for (int v = 0; v < 12; v++) begin
        run_cmp(k, va[v], vb[v], lat, res);
        exp_r = ref_cmp(va[v], vb[v], sg_of(k));
        exp_l = ref_len(va[v], vb[v], dg_of(k)) + 1;
        checks++;
        if (res !== exp_r) begin
          errors++;
          $display("[TB] FAIL sweep_result[k=%0d v=%0d a=%h b=%h]: got %b expected %b", k, v, va[v], vb[v], res, exp_r);
        end
        checks++;
        if (lat !== exp_l) begin
          errors++;
          $display("[TB] FAIL sweep_latency[k=%0d v=%0d]: got %0d expected %0d", k, v, lat, exp_l);
        end
        checks++;
        if (lat < 2 || (lat - 1) > (16 / dg_of(k))) begin
          errors++;
          $display("[TB] FAIL sweep_len_bound[k=%0d v=%0d]: got L=%0d expected 1..%0d", k, v, lat - 1, 16 / dg_of(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be an integer multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4: bits compared per cycle; SHALL satisfy 1 <= DIGIT <= WIDTH.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 The design SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start_valid  input  1  request to start a compare of a and b.
REQ-008 start_ready  output  1  block can accept a request.
REQ-009 a  input  WIDTH  operand A, sampled only on accept.
REQ-010 b  input  WIDTH  operand B, sampled only on accept.
REQ-011 gt  output  1  last result: A > B.
REQ-012 eq  output  1  last result: A == B.
REQ-013 lt  output  1  last result: A < B.
REQ-014 done  output  1  one-cycle pulse; gt/eq/lt are newly valid.
REQ-015 busy  output  1  compare in progress (state CMP or DONE).

Function
REQ-016 States SHALL be IDLE, CMP and DONE.
REQ-017 Accept SHALL occur on a rising edge with start_valid=1 and start_ready=1; start_ready SHALL be 1 only in IDLE.
REQ-018 On accept, A and B SHALL be latched into shift registers, the digit counter SHALL be cleared, and the state SHALL go IDLE->CMP.
REQ-019 When SIGNED=1, the MSB of both latched operands SHALL be inverted at capture, so the same unsigned digit compare gives the signed result.
REQ-020 In CMP, each cycle SHALL compare the most-significant unexamined DIGIT-bit digit of A against the same digit of B, MSB digit first.
REQ-021 If the digits differ, the state SHALL go CMP->DONE and the result SHALL be gt or lt from that digit (early termination).
REQ-022 If the digits are equal and it is not the last digit, the state SHALL stay in CMP, both registers SHALL shift left by DIGIT, and the counter SHALL increment.
REQ-023 If the last digit (N=WIDTH/DIGIT) is equal, the state SHALL go CMP->DONE with result eq.
REQ-024 In DONE, on the result edge: gt/eq/lt SHALL update, done SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-025 Latency: with L = digits examined (1..N), done SHALL be high in the cycle starting L+1 edges after the accept edge.
REQ-026 gt, eq and lt SHALL hold their value from one done until the next done; after the first done, exactly one of them SHALL be 1.
REQ-027 start_valid while busy=1 SHALL be ignored; it SHALL NOT be queued, and a and b SHALL NOT be sampled.
REQ-028 A request held through DONE SHALL be accepted on the first IDLE cycle, so the minimum spacing between accepts is L+2 cycles.
REQ-029 DIGIT=WIDTH SHALL give L=1 for every compare.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force state=IDLE, counter=0, gt=eq=lt=0, done=0 and busy=0, with start_ready=1 once rst_n is released.
REQ-031 Reset during CMP or DONE SHALL abort the compare with no done pulse; the previous result is lost.
REQ-032 After reset release, the first accepted request SHALL behave as in REQ-018..REQ-025.

Structure
REQ-033 Package serial_comparator_pkg SHALL hold the state encoding (IDLE/CMP/DONE) and the result encoding constants (GT/EQ/LT).
REQ-034 One combinational sub-module, digit_cmp, SHALL compare two DIGIT-bit values and output gt/eq/lt; serial_comparator SHALL instantiate it once.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-035 a=16'h1234, b=16'h1234, accept -> done in the 5th cycle after accept; eq=1, gt=lt=0.
REQ-036 a=16'h8000, b=16'h7FFF, SIGNED=0 -> L=1, done 2 cycles after accept, gt=1; the same operands with SIGNED=1 -> lt=1.
REQ-037 a=16'h00F1, b=16'h00F2 -> L=4, done 5 cycles after accept, lt=1; a=16'h0F00, b=16'h0E00 -> L=2, gt=1.
REQ-038 start_valid held high with a second operand pair -> start_ready=0 during CMP/DONE, second accept on the cycle after done, and the first result holds until the second done.
REQ-039 rst_n pulsed low during the 2nd CMP cycle of a=16'hFFFF, b=16'hFFFF -> no done pulse, outputs all 0, start_ready=1 after release; a new compare then completes correctly.
REQ-040 Sweep DIGIT in {1,4,16} with random signed and unsigned operands against a reference model -> results match and L never exceeds WIDTH/DIGIT.
